// File: rtl/branch_issue_ctrl.sv
// branch_issue_ctrl
// Sequencer between Instruction Identify and the BranchFacility. Decoded
// branches are buffered in a small circular FIFO and handed to the branch
// unit one at a time. The enable is never raised while the pipeline is
// stalled. After every consumed branch a fixed-length squash window
// (o_flush) discards the sequentially fetched instructions behind it.

module branch_issue_ctrl #(
    parameter int DEPTH        = 2,   // FIFO entries, power of 2, >= 2
    parameter int FLUSH_CYCLES = 2,   // squash window length, 0 disables it
    parameter int CNT_W        = 16   // issued-branch counter width
) (
    input  logic             i_clk,
    input  logic             i_rst,

    // Instruction Identify side
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic             i_i_form,
    input  logic             i_b_form,
    input  logic             i_cond_LR,
    input  logic             i_cond_CTR,
    input  logic             i_cond_TAR,

    // Pipeline control
    input  logic             i_stall,

    // BranchFacility side
    output logic             o_en,
    output logic [31:0]      o_instr,
    output logic             o_i_form,
    output logic             o_b_form,
    output logic             o_cond_LR,
    output logic             o_cond_CTR,
    output logic             o_cond_TAR,

    // Status
    output logic             o_flush,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_issue_count,
    output logic             o_err_form
);

    // ------------------------------------------------------------------
    // Local parameters and types
    // ------------------------------------------------------------------
    localparam int AW  = $clog2(DEPTH);   // FIFO index width
    localparam int PW  = AW + 1;          // pointer width incl. wrap bit
    localparam int EW  = 37;              // {flags[4:0], instr[31:0]}
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a buffered branch and no stall
        ST_ISSUE = 2'd1,   // branch presented to the branch unit
        ST_FLUSH = 2'd2    // squash window after a consumed branch
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    state_t           state;
    logic [FCW-1:0]   flush_cnt;
    logic [EW-1:0]    out_q;
    logic [CNT_W-1:0] issue_count;
    logic             err_form_q;

    // ------------------------------------------------------------------
    // Derived control
    // ------------------------------------------------------------------
    logic [4:0]    in_flags;
    logic [EW-1:0] in_entry;
    logic [2:0]    flag_ones;
    logic          form_bad;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flag bit order: 4=I-form, 3=B-form, 2=cond LR, 1=cond CTR, 0=cond TAR.
    assign in_flags = {i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR};
    assign in_entry = {in_flags, i_instr};

    // Pointers that differ only in the wrap bit mean every slot is in use.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Ready depends only on registered state so Identify can act on it
    // without a combinational loop through i_valid.
    assign o_ready = !i_rst && !full && (state != ST_FLUSH);
    assign push    = i_valid && o_ready;
    assign pop     = (state == ST_IDLE) && !empty && !i_stall;

    // Count the form flags of the incoming entry to detect non-one-hot vectors.
    always_comb begin
        // NOTE: every variable written here is assigned a default first, so no
        // path can leave it holding its old value and infer a latch.
        flag_ones = '0;
        for (int i = 0; i < 5; i++) begin
            flag_ones = flag_ones + 3'(in_flags[i]);
        end
        form_bad = (flag_ones != 3'd1);
    end

    // ------------------------------------------------------------------
    // FIFO storage write
    // ------------------------------------------------------------------
    // Write the accepted entry into the slot addressed by the write pointer.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // alone decide which slots hold valid data, so stale contents are
        // never observed.
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_entry;
        end
    end

    // Advance read and write pointers; they wrap naturally at 2*DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue sequencer
    // ------------------------------------------------------------------
    // Pop into the output register, hold it through stalls, count the
    // consumed branch and run the squash window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            flush_cnt   <= '0;
            out_q       <= '0;
            issue_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        out_q <= mem[rd_ptr[AW-1:0]];
                        state <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // The branch is consumed in the first unstalled cycle.
                    if (!i_stall) begin
                        if (issue_count != {CNT_W{1'b1}}) begin
                            issue_count <= issue_count + 1'b1;
                        end
                        if (FLUSH_CYCLES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_FLUSH;
                            flush_cnt <= FCW'(FLUSH_CYCLES);
                        end
                    end
                end

                ST_FLUSH: begin
                    // The window runs down regardless of stalls.
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == FCW'(1)) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Flag a malformed accept one cycle later; the entry itself is kept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_form_q <= 1'b0;
        end else begin
            err_form_q <= push && form_bad;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The enable is gated by the live stall so it can never coincide with it.
    assign o_en          = (state == ST_ISSUE) && !i_stall;
    assign o_flush       = (state == ST_FLUSH);
    assign o_busy        = (state != ST_IDLE) || !empty;
    assign o_issue_count = issue_count;
    assign o_err_form    = err_form_q;

    assign o_instr    = out_q[31:0];
    assign o_i_form   = out_q[36];
    assign o_b_form   = out_q[35];
    assign o_cond_LR  = out_q[34];
    assign o_cond_CTR = out_q[33];
    assign o_cond_TAR = out_q[32];

endmodule

// File: tb/tb_branch_issue_ctrl.sv
// tb_branch_issue_ctrl
// Two instances run in lock-step on the same stimulus: A with the default
// parameters (DEPTH=2, FLUSH_CYCLES=2, CNT_W=16) and B with FLUSH_CYCLES=0,
// CNT_W=2. Each is compared every cycle against a behavioural model that
// keeps the buffered branches as an ordered list and tracks what the unit is
// doing (idle / presenting a branch / squashing) with plain counters.

module tb_branch_issue_ctrl;

    localparam int DEPTH = 2;
    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_FLUSH = 2;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic [31:0] i_instr;
    logic        i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR;
    logic        i_stall;

    logic        ready_a, en_a, flush_a, busy_a, err_a;
    logic [31:0] instr_a;
    logic [4:0]  fl_a;
    logic [15:0] cnt_a;

    logic        ready_b, en_b, flush_b, busy_b, err_b;
    logic [31:0] instr_b;
    logic [4:0]  fl_b;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state, index 0 = instance A, 1 = instance B
    logic [36:0] m_buf   [2][DEPTH];
    int          m_cnt   [2];
    int          m_phase [2];
    int          m_left  [2];
    logic [36:0] m_out   [2];
    int          m_count [2];
    logic        m_err   [2];
    int          m_flush [2] = '{2, 0};
    int          m_max   [2] = '{65535, 3};

    branch_issue_ctrl u_dut_a (
        .i_clk(clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(ready_a), .i_instr(i_instr),
        .i_i_form(i_i_form), .i_b_form(i_b_form), .i_cond_LR(i_cond_LR),
        .i_cond_CTR(i_cond_CTR), .i_cond_TAR(i_cond_TAR),
        .i_stall(i_stall), .o_en(en_a), .o_instr(instr_a),
        .o_i_form(fl_a[4]), .o_b_form(fl_a[3]), .o_cond_LR(fl_a[2]),
        .o_cond_CTR(fl_a[1]), .o_cond_TAR(fl_a[0]),
        .o_flush(flush_a), .o_busy(busy_a), .o_issue_count(cnt_a),
        .o_err_form(err_a)
    );

    branch_issue_ctrl #(.DEPTH(2), .FLUSH_CYCLES(0), .CNT_W(2)) u_dut_b (
        .i_clk(clk), .i_rst(i_rst),
        .i_valid(i_valid), .o_ready(ready_b), .i_instr(i_instr),
        .i_i_form(i_i_form), .i_b_form(i_b_form), .i_cond_LR(i_cond_LR),
        .i_cond_CTR(i_cond_CTR), .i_cond_TAR(i_cond_TAR),
        .i_stall(i_stall), .o_en(en_b), .o_instr(instr_b),
        .o_i_form(fl_b[4]), .o_b_form(fl_b[3]), .o_cond_LR(fl_b[2]),
        .o_cond_CTR(fl_b[1]), .o_cond_TAR(fl_b[0]),
        .o_flush(flush_b), .o_busy(busy_b), .o_issue_count(cnt_b),
        .o_err_form(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_phase[i] = PH_IDLE;
            m_left[i]  = 0;
            m_out[i]   = '0;
            m_count[i] = 0;
            m_err[i]   = 1'b0;
        end
    endtask

    function automatic logic exp_ready(int i);
        return (m_cnt[i] < DEPTH) && (m_phase[i] != PH_FLUSH);
    endfunction

    // Compare every output of both instances against the model (inputs applied).
    task automatic check_outputs();
        check("a_ready", ready_a, exp_ready(0));
        check("a_en",    en_a,    (m_phase[0] == PH_ISSUE) && !i_stall);
        check("a_flush", flush_a, m_phase[0] == PH_FLUSH);
        check("a_busy",  busy_a,  (m_phase[0] != PH_IDLE) || (m_cnt[0] > 0));
        check("a_instr", instr_a, m_out[0][31:0]);
        check("a_flags", fl_a,    m_out[0][36:32]);
        check("a_count", cnt_a,   m_count[0]);
        check("a_err",   err_a,   m_err[0]);
        check("a_en_and_stall", en_a & i_stall, 1'b0);
        check("b_ready", ready_b, exp_ready(1));
        check("b_en",    en_b,    (m_phase[1] == PH_ISSUE) && !i_stall);
        check("b_flush", flush_b, 1'b0);
        check("b_busy",  busy_b,  (m_phase[1] != PH_IDLE) || (m_cnt[1] > 0));
        check("b_instr", instr_b, m_out[1][31:0]);
        check("b_flags", fl_b,    m_out[1][36:32]);
        check("b_count", cnt_b,   m_count[1]);
        check("b_err",   err_b,   m_err[1]);
    endtask

    task automatic reset_outputs_check(input string pfx);
        check({pfx, "_a_ready"}, ready_a, 1'b0);
        check({pfx, "_a_en"},    en_a,    1'b0);
        check({pfx, "_a_flush"}, flush_a, 1'b0);
        check({pfx, "_a_busy"},  busy_a,  1'b0);
        check({pfx, "_a_instr"}, {fl_a, instr_a}, 37'd0);
        check({pfx, "_a_count"}, cnt_a,   16'd0);
        check({pfx, "_a_err"},   err_a,   1'b0);
        check({pfx, "_b_ready"}, ready_b, 1'b0);
        check({pfx, "_b_busy"},  busy_b,  1'b0);
        check({pfx, "_b_count"}, cnt_b,   2'd0);
    endtask

    // Advance the model by one clock edge from the inputs of this cycle.
    task automatic model_step(input int i, input logic v, input logic [31:0] ins,
                              input logic [4:0] fl, input logic st);
        logic acc;
        acc = v && exp_ready(i);
        m_err[i] = acc && ($countones(fl) != 1);
        case (m_phase[i])
            PH_IDLE: begin
                if (m_cnt[i] > 0 && !st) begin
                    m_out[i] = m_buf[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) m_buf[i][k] = m_buf[i][k+1];
                    m_cnt[i]--;
                    m_phase[i] = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                if (!st) begin
                    if (m_count[i] < m_max[i]) m_count[i]++;
                    if (m_flush[i] > 0) begin
                        m_phase[i] = PH_FLUSH;
                        m_left[i]  = m_flush[i];
                    end else begin
                        m_phase[i] = PH_IDLE;
                    end
                end
            end
            default: begin
                if (m_left[i] == 1) m_phase[i] = PH_IDLE;
                else m_left[i]--;
            end
        endcase
        if (acc) begin
            m_buf[i][m_cnt[i]] = {fl, ins};
            m_cnt[i]++;
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then step the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [4:0] fl,
                         input logic st);
        @(negedge clk);
        i_valid = v;
        i_instr = ins;
        {i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR} = fl;
        i_stall = st;
        #1;
        check_outputs();
        model_step(0, v, ins, fl, st);
        model_step(1, v, ins, fl, st);
    endtask

    initial begin
        logic [4:0] fl;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_instr = '0;
        {i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR} = '0;
        i_stall = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        reset_outputs_check("rst");
        i_rst = 1'b0;

        // Single I-form branch, then idle through issue and flush
        cycle(1'b1, 32'h4800_0010, 5'b10000, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 5'b00000, 1'b0);
        check("first_count_a", cnt_a, 16'd1);

        // Stall held for 5 cycles while a branch is in ISSUE
        cycle(1'b1, 32'h4182_0008, 5'b01000, 1'b0);
        cycle(1'b0, 32'h0, 5'b00000, 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 5'b00000, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 5'b00000, 1'b0);

        // Three back-to-back branches while stalled: FIFO fills, third waits
        cycle(1'b1, 32'h1111_0001, 5'b00100, 1'b1);
        cycle(1'b1, 32'h2222_0002, 5'b00010, 1'b1);
        repeat (2) cycle(1'b1, 32'h3333_0003, 5'b00001, 1'b1);
        cycle(1'b1, 32'h3333_0003, 5'b00001, 1'b0);
        repeat (14) cycle(1'b0, 32'h0, 5'b00000, 1'b0);

        // Malformed flags (B-form + CTR): error pulse, entry still issued
        cycle(1'b1, 32'h4200_0040, 5'b01010, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 5'b00000, 1'b0);

        // Asynchronous reset in the middle of FLUSH with one entry buffered
        cycle(1'b1, 32'hAAAA_0001, 5'b10000, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 5'b10000, 1'b0);
        cycle(1'b0, 32'h0, 5'b00000, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        i_stall = 1'b0;
        #2;
        check("pre_rst_flush_a", flush_a, m_phase[0] == PH_FLUSH);
        check("pre_rst_busy_a", busy_a, 1'b1);
        i_rst = 1'b1;
        #1;
        reset_outputs_check("async_rst");
        model_reset();
        @(negedge clk);
        #1;
        i_rst = 1'b0;
        repeat (6) cycle(1'b0, 32'h0, 5'b00000, 1'b0);

        // Randomized traffic with mixed stalls and occasional bad flags
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) fl = 5'($urandom);
            else fl = 5'b00001 << $urandom_range(0, 4);
            cycle($urandom_range(0, 9) < 6, $urandom, fl, $urandom_range(0, 9) < 3);
        end
        repeat (10) cycle(1'b0, 32'h0, 5'b00000, 1'b0);
        check("b_count_saturated", cnt_b, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
